// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned shift-add multiplier with a start/busy/done
//               handshake. It produces a 2*WIDTH-bit product in WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;
    logic             w_accept;

    // Adder stage: carry-out is shifted into the accumulator MSB so full-scale
    // products are exact.
    assign w_addend           = r_q[0] ? r_a : '0;
    assign {w_carry, w_sum}   = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_acc_next         = {w_carry, w_sum[WIDTH-1:1]};
    assign w_q_next           = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_last             = (r_count == C_LAST);
    assign w_accept           = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_count <= '0;
            product <= '0;
        end else if (w_accept) begin
            r_a     <= multiplicand;
            r_q     <= multiplier;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_q     <= w_q_next;
            r_count <= r_count + 1'b1;
            // Product is captured on the final iteration so it is stable in DONE.
            if (w_last) begin
                product <= {w_acc_next, w_q_next};
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire
